// File: rtl/cache_miss_ctrl.sv
// -----------------------------------------------------------------------------
// cache_miss_ctrl
//
// Cache controller sitting between a CPU memory port and a 4-word-line cache
// backed by main memory.
//   * Read hits are answered combinationally from the cache (0-cycle latency).
//   * Read misses fetch the aligned 4-word line from memory, install it with a
//     single line-fill write, then answer the load (MEM_RD -> FILL -> RESP).
//   * Stores write through to memory with no allocation; on a store hit the
//     cached word is updated in the memory-ack cycle.
//   * Memory is lent to a DMA engine through a BR/BG handshake, only between
//     CPU memory transactions. Read hits keep being served while granted.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid/write/addr/wdata CPU request (held until req_ready)
//   req_ready, rsp_rdata      one-cycle completion pulse and load data
//   c_addr, c_readC, c_writeC, c_writeCword, c_wline  cache control
//   c_hit, c_rdata            cache lookup result
//   m_read, m_write, m_addr, m_wdata  memory request (held until m_ack)
//   m_ack, m_rline            memory completion pulse and returned line
//   dma_br, dma_bg            DMA bus request / grant
//
// Optional feature macro: CACHE_STATS_EN
//   When defined, adds stat_access / stat_hit read counters (wrap at 16'hFFFF).
// -----------------------------------------------------------------------------
module cache_miss_ctrl #(
  parameter int                   WORD_SIZE = 16,
  parameter int                   LINE_SIZE = 64,
  parameter logic [WORD_SIZE-1:0] ADDR_MASK = 16'hFFFC
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 req_ready,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic [WORD_SIZE-1:0] c_addr,
  output logic                 c_readC,
  output logic                 c_writeC,
  output logic                 c_writeCword,
  output logic [LINE_SIZE-1:0] c_wline,
  input  logic                 c_hit,
  input  logic [WORD_SIZE-1:0] c_rdata,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic                 m_ack,
  input  logic [LINE_SIZE-1:0] m_rline,
  input  logic                 dma_br,
  output logic                 dma_bg
`ifdef CACHE_STATS_EN
  ,
  output logic [WORD_SIZE-1:0] stat_access,
  output logic [WORD_SIZE-1:0] stat_hit
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MEM_RD = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_GRANT  = 3'd5;

  logic [2:0]           state_q,  state_d;
  logic [WORD_SIZE-1:0] base_q,   base_d;
  logic [1:0]           offset_q, offset_d;
  logic [WORD_SIZE-1:0] addr_q,   addr_d;
  logic [WORD_SIZE-1:0] wdata_q,  wdata_d;
  logic                 wr_hit_q, wr_hit_d;
  logic [LINE_SIZE-1:0] line_q,   line_d;

  // Word k of a line sits at the MSB end for k = 0.
  function automatic logic [WORD_SIZE-1:0] line_word(input logic [LINE_SIZE-1:0] line,
                                                     input logic [1:0]           off);
    logic [WORD_SIZE-1:0] w;
    case (off)
      2'd0:    w = line[LINE_SIZE-1               -: WORD_SIZE];
      2'd1:    w = line[LINE_SIZE-1-WORD_SIZE     -: WORD_SIZE];
      2'd2:    w = line[LINE_SIZE-1-2*WORD_SIZE   -: WORD_SIZE];
      2'd3:    w = line[LINE_SIZE-1-3*WORD_SIZE   -: WORD_SIZE];
      default: w = {WORD_SIZE{1'b0}};
    endcase
    return w;
  endfunction

  // Next-state and output decode; all outputs are held at 0 while in reset.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    offset_d     = offset_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_hit_d     = wr_hit_q;
    line_d       = line_q;
    req_ready    = 1'b0;
    rsp_rdata    = {WORD_SIZE{1'b0}};
    c_addr       = {WORD_SIZE{1'b0}};
    c_readC      = 1'b0;
    c_writeC     = 1'b0;
    c_writeCword = 1'b0;
    c_wline      = {LINE_SIZE{1'b0}};
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_addr       = {WORD_SIZE{1'b0}};
    m_wdata      = {WORD_SIZE{1'b0}};
    dma_bg       = 1'b0;

    if (reset_n) begin
      case (state_q)
        S_IDLE: begin
          c_addr  = req_addr;
          c_readC = req_valid;
          if (req_valid && !req_write && c_hit) begin
            req_ready = 1'b1;
            rsp_rdata = c_rdata;
          end else begin
            rsp_rdata = {WORD_SIZE{1'b0}};
          end
          // DMA takes precedence over any memory-bound request; the request
          // stays pending on the port and is re-evaluated after the grant.
          if (dma_br) begin
            state_d = S_GRANT;
          end else if (req_valid && !req_write && !c_hit) begin
            base_d   = req_addr & ADDR_MASK;
            offset_d = req_addr[1:0];
            state_d  = S_MEM_RD;
          end else if (req_valid && req_write) begin
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            wr_hit_d = c_hit;
            state_d  = S_MEM_WR;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MEM_RD: begin
          m_read = 1'b1;
          m_addr = base_q;
          if (m_ack) begin
            line_d  = m_rline;
            state_d = S_FILL;
          end else begin
            state_d = S_MEM_RD;
          end
        end
        S_FILL: begin
          c_writeC     = 1'b1;
          c_writeCword = 1'b0;
          c_addr       = base_q;
          c_wline      = line_q;
          state_d      = S_RESP;
        end
        S_RESP: begin
          req_ready = 1'b1;
          rsp_rdata = line_word(line_q, offset_q);
          state_d   = S_IDLE;
        end
        S_MEM_WR: begin
          m_write = 1'b1;
          m_addr  = addr_q;
          m_wdata = wdata_q;
          if (m_ack) begin
            req_ready = 1'b1;
            if (wr_hit_q) begin
              c_writeC     = 1'b1;
              c_writeCword = 1'b1;
              c_addr       = addr_q;
              c_wline      = {wdata_q, {(LINE_SIZE-WORD_SIZE){1'b0}}};
            end else begin
              c_writeC = 1'b0;
            end
            state_d = S_IDLE;
          end else begin
            state_d = S_MEM_WR;
          end
        end
        S_GRANT: begin
          dma_bg  = 1'b1;
          c_addr  = req_addr;
          c_readC = req_valid;
          if (req_valid && !req_write && c_hit) begin
            req_ready = 1'b1;
            rsp_rdata = c_rdata;
          end else begin
            rsp_rdata = {WORD_SIZE{1'b0}};
          end
          if (dma_br) begin
            state_d = S_GRANT;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  // State and transaction registers; reset abandons any memory transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      base_q   <= {WORD_SIZE{1'b0}};
      offset_q <= 2'b00;
      addr_q   <= {WORD_SIZE{1'b0}};
      wdata_q  <= {WORD_SIZE{1'b0}};
      wr_hit_q <= 1'b0;
      line_q   <= {LINE_SIZE{1'b0}};
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_hit_q <= wr_hit_d;
      line_q   <= line_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic hit_done_s;
  logic rd_done_s;

  // A read completes either as a hit from IDLE/GRANT or from RESP after a fill.
  assign hit_done_s = reset_n && req_valid && !req_write && c_hit &&
                      ((state_q == S_IDLE) || (state_q == S_GRANT));
  assign rd_done_s  = hit_done_s || (reset_n && (state_q == S_RESP));

  // Read access / hit counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_access <= {WORD_SIZE{1'b0}};
      stat_hit    <= {WORD_SIZE{1'b0}};
    end else begin
      if (rd_done_s) begin
        stat_access <= stat_access + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end else begin
        stat_access <= stat_access;
      end
      if (hit_done_s) begin
        stat_hit <= stat_hit + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end else begin
        stat_hit <= stat_hit;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
`timescale 1ns/1ps
// Bench for cache_miss_ctrl: behavioural cache and memory models, a table of
// single-request vectors, and hand-written DMA and mid-transaction reset runs.
module tb_cache_miss_ctrl;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready;
  logic [15:0] rsp_rdata;
  logic [15:0] c_addr;
  logic        c_readC, c_writeC, c_writeCword;
  logic [63:0] c_wline;
  logic        c_hit;
  logic [15:0] c_rdata;
  logic        m_read, m_write;
  logic [15:0] m_addr, m_wdata;
  logic        m_ack;
  logic [63:0] m_rline;
  logic        dma_br, dma_bg;
`ifdef CACHE_STATS_EN
  logic [15:0] stat_access, stat_hit;
`endif

  cache_miss_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_rdata(rsp_rdata),
    .c_addr(c_addr), .c_readC(c_readC), .c_writeC(c_writeC), .c_writeCword(c_writeCword),
    .c_wline(c_wline), .c_hit(c_hit), .c_rdata(c_rdata),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rline(m_rline),
    .dma_br(dma_br), .dma_bg(dma_bg)
`ifdef CACHE_STATS_EN
    , .stat_access(stat_access), .stat_hit(stat_hit)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural cache and memory ----------------
  logic        tb_init;
  logic        force_ack;
  logic [63:0] cl  [0:1023];
  logic        cv  [0:1023];
  logic [15:0] wmem[0:4095];
  logic        wval[0:4095];
  int          mcnt;
  logic        mdl_ack;

  function automatic logic [15:0] init_word(input logic [11:0] a);
    case (a)
      12'h040: return 16'h1111;
      12'h041: return 16'h2222;
      12'h042: return 16'h3333;
      12'h043: return 16'h4444;
      default: return {4'h0, a} ^ 16'hA5A5;
    endcase
  endfunction

  function automatic logic [15:0] word_of(input logic [63:0] l, input logic [1:0] o);
    return l[63-16*o -: 16];
  endfunction

  function automatic logic [63:0] set_word(input logic [63:0] l, input logic [1:0] o,
                                           input logic [15:0] w);
    logic [63:0] r;
    r = l;
    r[63-16*o -: 16] = w;
    return r;
  endfunction

  always_comb begin
    c_hit   = c_readC && cv[c_addr[11:2]];
    c_rdata = word_of(cl[c_addr[11:2]], c_addr[1:0]);
  end

  always_comb begin
    m_rline = 64'h0;
    for (int k = 0; k < 4; k++) begin
      m_rline[63-16*k -: 16] = wval[m_addr[11:0] + 12'(k)] ? wmem[m_addr[11:0] + 12'(k)]
                                                           : init_word(m_addr[11:0] + 12'(k));
    end
  end

  assign mdl_ack = (m_read || m_write) && (mcnt == MEM_LAT - 1);
  assign m_ack   = mdl_ack || force_ack;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) cv[i] <= 1'b0;
    end else if (c_writeC) begin
      if (c_writeCword) cl[c_addr[11:2]] <= set_word(cl[c_addr[11:2]], c_addr[1:0], c_wline[63:48]);
      else begin
        cl[c_addr[11:2]] <= c_wline;
        cv[c_addr[11:2]] <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 4096; i++) wval[i] <= 1'b0;
      mcnt <= 0;
    end else if (m_read || m_write) begin
      if (mdl_ack) begin
        mcnt <= 0;
        if (m_write) begin
          wmem[m_addr[11:0]] <= m_wdata;
          wval[m_addr[11:0]] <= 1'b1;
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct { logic wr; logic [15:0] data; } sb_t;
  sb_t sb[$];

  typedef struct {
    logic wr; logic [15:0] addr; logic [15:0] wdata; logic [15:0] rdata; int lat;
    logic mem; logic [15:0] maddr; logic [1:0] cw; logic [15:0] caddr; logic [15:0] cwhi;
  } vec_t;
  vec_t vecs[$];

  int          checks = 0;
  int          errors = 0;
  logic        got_ready;
  logic        cap_mem;
  logic [15:0] cap_maddr;
  logic [1:0]  cap_cw;
  logic [15:0] cap_caddr, cap_cwhi;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic err(input string name, input logic [63:0] act, input logic [63:0] exp);
    errors++;
    $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // One cycle of observation at the falling edge: invariants, completions, captures.
  task automatic sample_cycle();
    sb_t e;
    @(negedge clk);
    if (m_read && m_write) err("rd_wr_overlap", 1, 0);
    if ((m_read || m_write) && dma_bg) err("mem_while_granted", 1, 0);
    if (c_readC && c_writeC) err("crd_cwr_overlap", 1, 0);
    got_ready = req_ready;
    if (req_ready) begin
      if (sb.size() == 0) begin
        err("unexpected_ready", 1, 0);
      end else begin
        e = sb.pop_front();
        if (!e.wr) chk("rsp_rdata", rsp_rdata, e.data);
      end
    end
    if (m_read || m_write) begin
      cap_mem   = 1'b1;
      cap_maddr = m_addr;
    end
    if (c_writeC) begin
      cap_cw    = c_writeCword ? 2'd2 : 2'd1;
      cap_caddr = c_addr;
      cap_cwhi  = c_wline[63:48];
    end
  endtask

  task automatic clear_caps();
    cap_mem = 1'b0; cap_maddr = 16'h0; cap_cw = 2'd0; cap_caddr = 16'h0; cap_cwhi = 16'h0;
  endtask

  task automatic wait_ready(input string name, input int exp_lat);
    int  lat;
    bit  done;
    lat  = 0;
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      sample_cycle();
      if (got_ready) begin
        done = 1'b1;
        break;
      end
      lat++;
    end
    if (!done) err({name, "_timeout"}, 0, 1);
    else chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_data, input int exp_lat, input string name);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    sb.push_back('{wr: wr, data: exp_data});
    clear_caps();
    wait_ready(name, exp_lat);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  function automatic vec_t mk(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] rdata, input int lat, input logic mem,
                              input logic [15:0] maddr, input logic [1:0] cw,
                              input logic [15:0] caddr, input logic [15:0] cwhi);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.lat = lat;
    v.mem = mem; v.maddr = maddr; v.cw = cw; v.caddr = caddr; v.cwhi = cwhi;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // wr addr wdata rdata lat mem maddr cw caddr cwhi (cw: 0 none, 1 fill, 2 word)
    vecs.push_back(mk(1'b0, 16'h0042, 16'h0000, 16'h3333, MEM_LAT+2, 1'b1, 16'h0040, 2'd1, 16'h0040, 16'h1111));
    vecs.push_back(mk(1'b0, 16'h0043, 16'h0000, 16'h4444, 0,         1'b0, 16'h0000, 2'd0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1'b0, 16'h0040, 16'h0000, 16'h1111, 0,         1'b0, 16'h0000, 2'd0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1'b1, 16'h0041, 16'hBEEF, 16'h0000, MEM_LAT,   1'b1, 16'h0041, 2'd2, 16'h0041, 16'hBEEF));
    vecs.push_back(mk(1'b0, 16'h0041, 16'h0000, 16'hBEEF, 0,         1'b0, 16'h0000, 2'd0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1'b1, 16'h0100, 16'hDEAD, 16'h0000, MEM_LAT,   1'b1, 16'h0100, 2'd0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1'b0, 16'h0102, 16'h0000, 16'hA4A7, MEM_LAT+2, 1'b1, 16'h0100, 2'd1, 16'h0100, 16'hDEAD));
    vecs.push_back(mk(1'b0, 16'h0100, 16'h0000, 16'hDEAD, 0,         1'b0, 16'h0000, 2'd0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1'b0, 16'h0201, 16'h0000, 16'hA7A4, MEM_LAT+2, 1'b1, 16'h0200, 2'd1, 16'h0200, 16'hA7A5));
    vecs.push_back(mk(1'b0, 16'h0203, 16'h0000, 16'hA7A6, 0,         1'b0, 16'h0000, 2'd0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1'b1, 16'h0202, 16'h1234, 16'h0000, MEM_LAT,   1'b1, 16'h0202, 2'd2, 16'h0202, 16'h1234));
    vecs.push_back(mk(1'b0, 16'h0202, 16'h0000, 16'h1234, 0,         1'b0, 16'h0000, 2'd0, 16'h0000, 16'h0000));

    reset_n = 1'b0; tb_init = 1'b1; force_ack = 1'b0; dma_br = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", |{req_ready, rsp_rdata, c_addr, c_readC, c_writeC, c_writeCword,
                               c_wline, m_read, m_write, m_addr, m_wdata, dma_bg}, 1'b0);
    reset_n = 1'b1; tb_init = 1'b0;
    @(posedge clk); #1;

    // Table-driven single requests, issued back to back.
    foreach (vecs[i]) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].lat, $sformatf("v%0d", i));
      chk($sformatf("v%0d_mem_used", i), cap_mem, vecs[i].mem);
      if (vecs[i].mem) chk($sformatf("v%0d_m_addr", i), cap_maddr, vecs[i].maddr);
      chk($sformatf("v%0d_cache_write_kind", i), cap_cw, vecs[i].cw);
      if (vecs[i].cw != 2'd0) begin
        chk($sformatf("v%0d_c_addr", i), cap_caddr, vecs[i].caddr);
        chk($sformatf("v%0d_c_wline_hi", i), cap_cwhi, vecs[i].cwhi);
      end
    end

    // DMA request together with a read miss: DMA wins, hits still served.
    dma_br = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0300;
    sb.push_back('{wr: 1'b0, data: 16'hA6A5});
    clear_caps();
    sample_cycle();
    chk("dma_miss_no_ready", got_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      sample_cycle();
      chk($sformatf("dma_bg_hold%0d", k), dma_bg, 1'b1);
      chk($sformatf("dma_no_mread%0d", k), m_read, 1'b0);
    end
    @(posedge clk); #1;
    req_addr = 16'h0040;
    sb.push_front('{wr: 1'b0, data: 16'h1111});
    sample_cycle();
    chk("grant_hit_ready", got_ready, 1'b1);
    @(posedge clk); #1;
    req_addr = 16'h0300; dma_br = 1'b0;
    sample_cycle();
    chk("grant_last_cycle_bg", dma_bg, 1'b1);
    @(posedge clk); #1;
    sample_cycle();
    chk("grant_released_bg", dma_bg, 1'b0);
    chk("grant_released_no_ready", got_ready, 1'b0);
    wait_ready("dma_miss", MEM_LAT + 1);
    chk("dma_miss_m_addr", cap_maddr, 16'h0300);
    @(posedge clk); #1;
    req_valid = 1'b0;

    // Reset during MEM_RD, then a stray ack: nothing must complete.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0400;
    sb.push_back('{wr: 1'b0, data: 16'h0000});
    sample_cycle();
    @(posedge clk); #1;
    sample_cycle();
    chk("rst_seq_in_mem_rd", m_read, 1'b1);
    chk("rst_seq_m_addr", m_addr, 16'h0400);
    reset_n = 1'b0; req_valid = 1'b0;
    sb.delete();
    #1;
    chk("midrun_reset_outputs_zero", |{req_ready, rsp_rdata, c_addr, c_readC, c_writeC, c_writeCword,
                                      c_wline, m_read, m_write, m_addr, m_wdata, dma_bg}, 1'b0);
    @(posedge clk);
    sample_cycle();
    reset_n = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b1;
    sample_cycle();
    chk("stray_ack_no_ready", got_ready, 1'b0);
    chk("stray_ack_no_mread", m_read, 1'b0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample_cycle();
      chk($sformatf("post_reset_quiet%0d", k), m_read | m_write | req_ready, 1'b0);
      @(posedge clk); #1;
    end
    do_req(1'b0, 16'h0040, 16'h0000, 16'h1111, 0, "post_reset_hit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Cache controller between the pipeline's memory stage (or instruction fetch port) and the 4-word-line cache/main memory. Serves read hits combinationally from the cache. On a read miss it fetches the aligned 4-word line from memory and installs it. Writes go through to memory with no allocation, and the cache copy is updated on a hit. Memory is released to the DMA controller via a BR/BG handshake between CPU transactions.

## Interface
Parameters:
- `ADDR_MASK`, default 16'hFFFC: line-base mask; 4 words per line.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CPU access request, held until `req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in `WORD_SIZE`: word address.
- `req_wdata` in `WORD_SIZE`: store data.
- `req_ready` out 1: one-cycle completion pulse.
- `rsp_rdata` out `WORD_SIZE`: load data, valid while `req_ready` is high.
- `c_addr` out `WORD_SIZE`: cache address.
- `c_readC` out 1: cache read/lookup.
- `c_writeC` out 1: cache write.
- `c_writeCword` out 1: 1 = single-word update, 0 = line fill.
- `c_wline` out `LINE_SIZE`: cache write data.
- `c_hit` in 1: cache hit.
- `c_rdata` in `WORD_SIZE`: cache read data.
- `m_read` out 1: memory line read.
- `m_write` out 1: memory word write.
- `m_addr` out `WORD_SIZE`: memory address.
- `m_wdata` out `WORD_SIZE`: memory write data.
- `m_ack` in 1: memory completion pulse.
- `m_rline` in `LINE_SIZE`: memory read line, valid with `m_ack`.
- `dma_br` in 1: DMA bus request.
- `dma_bg` out 1: DMA bus grant.

## Operation
- States: IDLE, MEM_RD, FILL, RESP, MEM_WR, GRANT.
- IDLE:
  - `c_addr` = `req_addr` and `c_readC` = `req_valid`.
  - Read with `c_hit` = 1: `req_ready` = 1 and `rsp_rdata` = `c_rdata` in the same cycle; stay in IDLE.
  - Read miss: latch base = `req_addr & ADDR_MASK` and offset = `req_addr[1:0]`; go to MEM_RD.
  - Write: latch address, data and `c_hit` (wr_hit); go to MEM_WR.
  - `dma_br` = 1 with no memory-bound request this cycle: go to GRANT. A read hit in the same cycle still completes.
  - If a miss or write coincides with `dma_br`, DMA wins: go to GRANT, and the request is re-evaluated afterwards.
- MEM_RD:
  - `m_read` = 1, `m_addr` = base, held until `m_ack`.
  - On `m_ack`: register `m_rline`; go to FILL.
- FILL:
  - One cycle of `c_writeC` = 1, `c_writeCword` = 0, `c_addr` = base, `c_wline` = fetched line.
  - Go to RESP.
- RESP:
  - `req_ready` = 1.
  - `rsp_rdata` = line word at offset k, which occupies bits [`LINE_SIZE`-1-16k -: 16]; offset 0 is the MSB word.
  - Go to IDLE.
- MEM_WR:
  - `m_write` = 1, `m_addr`/`m_wdata` = latched values, held until `m_ack`.
  - On `m_ack`: `req_ready` = 1. If wr_hit: `c_writeC` = 1, `c_writeCword` = 1, `c_addr` = latched address, `c_wline` = {wdata, 48'b0}.
  - Go to IDLE.
- GRANT:
  - `dma_bg` = 1; all `m_*` outputs = 0.
  - Read requests with `c_hit` = 1 are served as in IDLE.
  - Misses and writes wait.
  - `dma_br` = 0: go to IDLE with `dma_bg` = 0 on the next cycle.
- `m_ack` outside MEM_RD/MEM_WR is ignored.

## Timing
- Reset (asynchronous): state = IDLE; all outputs 0; latched line, address and data cleared. A memory transaction in flight is abandoned, and any later `m_ack` is ignored.
- Latency:
  - Read hit: 0 cycles; `req_ready` in the request cycle.
  - Read miss: memory latency L (cycles from `m_read` to `m_ack`) + 2. Order is MEM_RD → FILL → RESP.
  - Write: L cycles; `req_ready` in the `m_ack` cycle.
- `m_read`/`m_write` are never high together, and never high while `dma_bg` = 1.
- `dma_bg` rises at most 1 cycle after `dma_br` when in IDLE. Otherwise it rises after the current transaction returns to IDLE.
- `c_writeC` and `c_readC` are never high in the same cycle.
- `req_ready` is exactly one cycle per request. The requester may present a new request in the following cycle.

## Configuration
- `CACHE_STATS_EN` defined:
  - Adds outputs `stat_access` and `stat_hit`, both `WORD_SIZE`, reset to 0.
  - `stat_access` increments on every completed read (`req_ready` with `req_write` = 0).
  - `stat_hit` increments when that read completed from IDLE/GRANT as a hit.
  - Both wrap at 16'hFFFF → 0.
- `CACHE_STATS_EN` undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Cold read at `req_addr` = 16'h0042, memory returns line 64'h1111_2222_3333_4444 after L = 3:
  - `m_addr` = 16'h0040.
  - FILL writes the line with `c_addr` = 16'h0040.
  - `rsp_rdata` = 16'h3333 at cycle 5.
- Read 16'h0043 after the fill above: `req_ready` in the same cycle, `rsp_rdata` = 16'h4444, no `m_read`.
- Write 16'hBEEF to 16'h0041 (hit):
  - `m_write` is held until `m_ack`.
  - In the ack cycle, `c_writeCword` = 1 and `c_wline`[63:48] = 16'hBEEF.
  - A following read of 16'h0041 returns 16'hBEEF.
- Write to 16'h0100 (miss): memory write only; `c_writeC` stays 0.
- `dma_br` = 1 together with a read miss:
  - `dma_bg` = 1 next cycle and no `m_read` while granted.
  - A concurrent hit read of 16'h0040 completes.
  - After `dma_br` drops, the miss proceeds.
- `reset_n` low during MEM_RD with `m_ack` pulsing after release: all outputs 0, state IDLE, `req_ready` never pulses.
